// File: rtl/vga_timing_generator.sv
// VGA raster timing generator: pixel-rate divider, h/v counters, and a registered
// output stage that gates colour and aligns syncs/blank with the returned pixel.
module vga_timing_generator #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [29:0] rgb_in,
    output logic [9:0]  screen_x,
    output logic [9:0]  screen_y,
    output logic        active_area,
    output logic        pix_en,
    output logic        frame_start,
    output logic [9:0]  vga_r,
    output logic [9:0]  vga_g,
    output logic [9:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vga_clk
);

    localparam int unsigned CNT_W    = 10;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic [29:0]      rgb_q;
    logic             h_last;
    logic             v_last;
    logic             hs_c;
    logic             vs_c;

    assign pix_en      = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign vga_clk     = (div_cnt >= DIV_W'(CLK_DIV / 2));
    assign h_last      = (h_cnt == CNT_W'(H_TOTAL - 1));
    assign v_last      = (v_cnt == CNT_W'(V_TOTAL - 1));
    assign active_area = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
    assign hs_c        = (h_cnt >= CNT_W'(HS_START)) && (h_cnt < CNT_W'(HS_END));
    assign vs_c        = (v_cnt >= CNT_W'(VS_START)) && (v_cnt < CNT_W'(VS_END));
    assign screen_x    = h_cnt;
    assign screen_y    = v_cnt;
    assign {vga_r, vga_g, vga_b} = rgb_q;

    // Clock divider producing one pix_en strobe per pixel period
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (pix_en) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Raster counters; frame_start marks the cycle after the (last,last) -> (0,0) wrap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en && h_last && v_last;
            if (pix_en) begin
                if (h_last) begin
                    h_cnt <= '0;
                    v_cnt <= v_last ? '0 : v_cnt + CNT_W'(1);
                end else begin
                    h_cnt <= h_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Output stage: one pixel of latency, colour forced to 0 outside the active area
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q       <= '0;
            vga_blank_n <= 1'b0;
            vga_hs      <= ~SYNC_POL;
            vga_vs      <= ~SYNC_POL;
        end else if (pix_en) begin
            rgb_q       <= active_area ? rgb_in : '0;
            vga_blank_n <= active_area;
            vga_hs      <= hs_c ? SYNC_POL : ~SYNC_POL;
            vga_vs      <= vs_c ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench: default-timing instance for reset/horizontal/colour behaviour,
// reduced-parameter instance for full raster, vertical sync and frame period.
module tb_vga_timing_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Default-parameter instance
    logic        rst_d;
    logic        mode;
    logic [29:0] rgb_d;
    logic [9:0]  sx_d, sy_d, r_d, g_d, b_d;
    logic        act_d, pe_d, fs_d, hs_d, vs_d, bl_d, vclk_d;

    assign rgb_d = mode ? {sx_d, sy_d, 10'h155} : 30'h3FFFFFFF;

    vga_timing_generator dut_d (
        .clk(clk), .reset_n(rst_d), .rgb_in(rgb_d),
        .screen_x(sx_d), .screen_y(sy_d), .active_area(act_d), .pix_en(pe_d),
        .frame_start(fs_d), .vga_r(r_d), .vga_g(g_d), .vga_b(b_d),
        .vga_hs(hs_d), .vga_vs(vs_d), .vga_blank_n(bl_d), .vga_clk(vclk_d)
    );

    // Reduced instance: H 4/1/2/1 (total 8), V 3/1/1/1 (total 6), CLK_DIV 3
    logic        rst_r;
    logic [29:0] rgb_r;
    logic [9:0]  sx_r, sy_r, r_r, g_r, b_r;
    logic        act_r, pe_r, fs_r, hs_r, vs_r, bl_r, vclk_r;

    assign rgb_r = {sx_r, sy_r, 10'h155};

    vga_timing_generator #(
        .CLK_DIV(3), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
    ) dut_r (
        .clk(clk), .reset_n(rst_r), .rgb_in(rgb_r),
        .screen_x(sx_r), .screen_y(sy_r), .active_area(act_r), .pix_en(pe_r),
        .frame_start(fs_r), .vga_r(r_r), .vga_g(g_r), .vga_b(b_r),
        .vga_hs(hs_r), .vga_vs(vs_r), .vga_blank_n(bl_r), .vga_clk(vclk_r)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Walks the reduced instance n_edges clocks after a reset release, checking every cycle
    task automatic run_reduced(input int n_edges);
        int n, p, q, qx, qy;
        logic [29:0] er;
        logic        act;
        for (int e = 1; e <= n_edges; e++) begin
            step(1);
            n = e / 3;
            p = n % 48;
            check("r_pix_en", 32'(pe_r), 32'((e % 3) == 2));
            check("r_vga_clk", 32'(vclk_r), 32'((e % 3) >= 1));
            check("r_screen_x", 32'(sx_r), 32'(p % 8));
            check("r_screen_y", 32'(sy_r), 32'(p / 8));
            check("r_active", 32'(act_r), 32'(((p % 8) < 4) && ((p / 8) < 3)));
            check("r_frame_start", 32'(fs_r), 32'((e % 144) == 0));
            if (n == 0) begin
                check("r_rgb_init", 32'({r_r, g_r, b_r}), 32'h0);
                check("r_blank_init", 32'(bl_r), 32'h0);
                check("r_hs_init", 32'(hs_r), 32'h1);
                check("r_vs_init", 32'(vs_r), 32'h1);
            end else begin
                q   = (n - 1) % 48;
                qx  = q % 8;
                qy  = q / 8;
                act = (qx < 4) && (qy < 3);
                er  = act ? {10'(qx), 10'(qy), 10'h155} : 30'h0;
                check("r_rgb", 32'({r_r, g_r, b_r}), 32'(er));
                check("r_blank", 32'(bl_r), 32'(act));
                check("r_hs", 32'(hs_r), 32'(!((qx >= 5) && (qx < 7))));
                check("r_vs", 32'(vs_r), 32'(qy != 4));
            end
        end
    endtask

    initial begin
        int px, hs_low, x;
        logic [29:0] er;
        rst_d = 1'b0;
        rst_r = 1'b0;
        mode  = 1'b1;
        step(3);

        // Reset values
        check("rst_screen_x", 32'(sx_d), 32'h0);
        check("rst_screen_y", 32'(sy_d), 32'h0);
        check("rst_active", 32'(act_d), 32'h1);
        check("rst_pix_en", 32'(pe_d), 32'h0);
        check("rst_frame_start", 32'(fs_d), 32'h0);
        check("rst_rgb", 32'({r_d, g_d, b_d}), 32'h0);
        check("rst_blank", 32'(bl_d), 32'h0);
        check("rst_hs", 32'(hs_d), 32'h1);
        check("rst_vs", 32'(vs_d), 32'h1);
        check("rst_vga_clk", 32'(vclk_d), 32'h0);
        check("rst_r_hs", 32'(hs_r), 32'h1);

        // Release: pix_en on clk 1, first output load on clk 2
        rst_d = 1'b1;
        step(1);
        check("e1_pix_en", 32'(pe_d), 32'h1);
        check("e1_vga_clk", 32'(vclk_d), 32'h1);
        check("e1_screen_x", 32'(sx_d), 32'h0);
        check("e1_blank", 32'(bl_d), 32'h0);
        step(1);
        check("e2_pix_en", 32'(pe_d), 32'h0);
        check("e2_vga_clk", 32'(vclk_d), 32'h0);
        check("e2_screen_x", 32'(sx_d), 32'h1);
        check("e2_blank", 32'(bl_d), 32'h1);
        check("e2_rgb", 32'({r_d, g_d, b_d}), 32'h155);
        check("e2_hs", 32'(hs_d), 32'h1);

        // Line 0 with rgb_in = {x,y,155}: one-pixel latency, hsync window, blanking
        hs_low = 0;
        for (int k = 2; k <= 800; k++) begin
            step(2);
            px = k - 1;
            check("h_screen_x", 32'(sx_d), 32'(k % 800));
            check("h_screen_y", 32'(sy_d), 32'(k / 800));
            check("h_pix_en", 32'(pe_d), 32'h0);
            check("h_blank", 32'(bl_d), 32'(px < 640));
            check("h_hs", 32'(hs_d), 32'(!((px >= 656) && (px < 752))));
            check("h_vs", 32'(vs_d), 32'h1);
            check("h_vga_r", 32'(r_d), (px < 640) ? 32'(px) : 32'h0);
            check("h_vga_b", 32'(b_d), (px < 640) ? 32'h155 : 32'h0);
            if (hs_d == 1'b0) hs_low++;
        end
        check("h_sync_width", 32'(hs_low), 32'd96);

        // Line 1 with rgb_in all ones: gated to 0 in blanking
        mode = 1'b0;
        for (int k = 801; k <= 1600; k++) begin
            step(2);
            x  = k - 801;
            er = (x < 640) ? 30'h3FFFFFFF : 30'h0;
            check("c_rgb", 32'({r_d, g_d, b_d}), 32'(er));
            check("c_blank", 32'(bl_d), 32'(x < 640));
            check("c_screen_y", 32'(sy_d), 32'(1 + (k / 800) - 1 + ((k == 1600) ? 1 : 0) - ((k == 1600) ? 1 : 0)));
        end
        check("c_line2_y", 32'(sy_d), 32'd2);

        // Mid-frame reset while hsync is asserted
        step(1400);
        check("m_screen_x", 32'(sx_d), 32'd700);
        check("m_hs_before", 32'(hs_d), 32'h0);
        rst_d = 1'b0;
        #1;
        check("m_screen_x_rst", 32'(sx_d), 32'h0);
        check("m_screen_y_rst", 32'(sy_d), 32'h0);
        check("m_hs_rst", 32'(hs_d), 32'h1);
        check("m_vs_rst", 32'(vs_d), 32'h1);
        check("m_blank_rst", 32'(bl_d), 32'h0);
        check("m_rgb_rst", 32'({r_d, g_d, b_d}), 32'h0);
        check("m_fs_rst", 32'(fs_d), 32'h0);

        // Reduced raster: run into vsync of the first frame, reset, then two full frames
        @(negedge clk);
        rst_r = 1'b1;
        run_reduced(100);
        check("rm_vs_before", 32'(vs_r), 32'h0);
        rst_r = 1'b0;
        #1;
        check("rm_vs_rst", 32'(vs_r), 32'h1);
        check("rm_screen_x_rst", 32'(sx_r), 32'h0);
        check("rm_screen_y_rst", 32'(sy_r), 32'h0);
        check("rm_fs_rst", 32'(fs_r), 32'h0);
        @(negedge clk);
        rst_r = 1'b1;
        run_reduced(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
